clock_bcd_hms: RTL and testbench
================================

Name: clock_bcd_hms

Overview:
- Parametrised successor to the 12-hour BCD wall clock.
- Keeps time as packed-BCD HH:MM:SS and supports runtime 12h/24h mode, synchronous time load with BCD validation, and a tick prescaler.
- Sits between the one-second strobe source and display/alarm logic in the counter family.

Parameters:
- TICK_DIV, 1: number of ena pulses per one-second advance (1..65535); 1 disables the prescaler.
- TICK_W, 16: width of the prescaler counter; must satisfy 2^TICK_W > TICK_DIV.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- ena  input  1  tick strobe, one clk wide
- mode_24h  input  1  1 = 24-hour display, 0 = 12-hour with pm
- load  input  1  synchronous time load strobe
- load_hh  input  8  BCD hours, interpreted in the current mode
- load_mm  input  8  BCD minutes
- load_ss  input  8  BCD seconds
- load_pm  input  1  pm flag for a 12h load; ignored in 24h
- hh  output  8  BCD hours
- mm  output  8  BCD minutes
- ss  output  8  BCD seconds
- pm  output  1  pm flag; forced 0 in 24h mode
- day_wrap  output  1  one-cycle pulse on the midnight rollover
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (async assert, sync release):
  - 12h mode: hh=0x12, mm=0x00, ss=0x00, pm=0.
  - 24h mode: hh=0x00, mm=0x00, ss=0x00, pm=0.
  - Internal: prescaler=0, mode_q=mode_24h, day_wrap=0, load_err=0.
- Per-cycle priority: load > mode change > tick. Only one action per cycle.
- Prescaler:
  - Counts ena pulses. The tick fires on the ena at which the count equals TICK_DIV-1; the count then returns to 0.
  - A load clears the prescaler.
  - A mode change does not clear the prescaler, but a tick coinciding with a mode change is deferred by one cycle, not lost.
- Tick (registered; outputs update on the clk edge that samples the qualifying ena, latency 1):
  - ss ones digit counts 0..9. ss tens counts 0..5, carrying at 59.
  - mm behaves the same as ss.
  - 12h hours: 11:59:59 -> 12:00:00 with pm toggled; 12:59:59 -> 01:00:00 with pm unchanged.
  - 24h hours: 23:59:59 -> 00:00:00.
  - day_wrap pulses on the 24h 23:59:59 -> 00:00:00 rollover, and in 12h mode on 11:59:59 PM -> 12:00:00 AM.
- Load:
  - Valid when every nibble is <= 9, mm and ss are <= 0x59, and hh is in 0x01..0x12 (12h) or 0x00..0x23 (24h).
  - Valid load: registers take the load values in the next cycle; pm takes load_pm in 12h, 0 in 24h.
  - Invalid load: time is unchanged and load_err pulses for one cycle.
  - A load in the same cycle as ena: the load wins and that tick is dropped.
- Mode change: mode_24h is sampled into mode_q. When mode_24h != mode_q, hours are converted in one cycle and mm/ss are untouched.
  - 12h -> 24h: 12AM->00, 01-11AM unchanged, 12PM->12, 01-11PM->13-23; pm cleared.
  - 24h -> 12h: 00->12AM, 01-11->AM, 12->12PM, 13-23->01-11PM.
- Reset mid-operation: all state returns to reset values immediately, including a pending deferred tick.

Optional Feature:
- Macro: CLOCK_BCD_HMS_ALARM_EN.
- When defined, these ports are added:
  - alarm_set (input, 1)
  - alarm_hh (input, 8)
  - alarm_mm (input, 8)
  - alarm_pm (input, 1)
  - alarm (output, 1)
- alarm_set captures the alarm time, normalised internally to 24h; invalid values are rejected via load_err.
- alarm pulses for one cycle when a tick produces mm == alarm minute and ss == 0x00 with matching hours.
- Alarm reset state: disarmed until the first valid alarm_set.
- When the macro is undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Package clock_bcd_pkg holds:
  - typedef bcd2_t (logic [7:0]);
  - constants BCD_59, BCD_12, BCD_23;
  - functions bcd_valid, hr12_to_24, hr24_to_12.
- Sub-module bcd_mod_counter (parameter MAX as BCD) provides a two-digit BCD counter with inc, load, and a wrap output.
  - Instantiated twice, for ss and mm.
  - Hours stay in the top level because of the mode logic.

Test Plan:
- Reset with mode_24h=0, then hold ena high for 3600 cycles -> hh=0x01, mm=0x00, ss=0x00, pm=0.
- Load 11:59:59 PM in 12h, then one ena -> 12:00:00, pm=0, day_wrap=1 for exactly one cycle.
- Load 0x12:0x30:0x00 PM in 12h, then toggle mode_24h to 1 -> next cycle hh=0x12, pm=0; load 0x00:0x00:0x00, toggle to 12h -> hh=0x12, pm=0.
- Load hh=0x13 in 12h mode, or mm=0x5A -> load_err pulses and time is unchanged; load and ena in the same cycle -> the load value holds for that cycle.
- TICK_DIV=4: 8 ena pulses -> ss=0x02; assert reset_n low between pulses -> prescaler restarts from 0.
- With CLOCK_BCD_HMS_ALARM_EN defined: set the alarm to 07:00 AM, load 06:59:59 AM, one tick -> alarm=1 for one cycle; no pulse at 07:00 PM.

Source files
------------

// File: rtl/clock_bcd_hms_pkg.sv
// Shared BCD types, limits and hour-conversion helpers for the HH:MM:SS clock.
// Also used by the optional alarm logic (CLOCK_BCD_HMS_ALARM_EN).
package clock_bcd_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t BCD_59 = 8'h59;
  localparam bcd2_t BCD_12 = 8'h12;
  localparam bcd2_t BCD_23 = 8'h23;

  function automatic logic bcd_valid(input bcd2_t v, input bcd2_t max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  function automatic bcd2_t bcd_inc(input bcd2_t v);
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Hours never exceed 23, so five binary bits are enough.
  function automatic logic [4:0] bcd_to_bin(input bcd2_t v);
    return 5'(v[7:4]) * 5'd10 + 5'(v[3:0]);
  endfunction

  function automatic bcd2_t bin_to_bcd(input logic [4:0] b);
    if (b >= 5'd20)
      return {4'd2, 4'(b - 5'd20)};
    if (b >= 5'd10)
      return {4'd1, 4'(b - 5'd10)};
    return {4'd0, 4'(b)};
  endfunction

  function automatic bcd2_t hr12_to_24(input bcd2_t h, input logic p);
    logic [4:0] b;
    b = bcd_to_bin(h);
    if (b == 5'd12)
      b = 5'd0;
    if (p)
      b = b + 5'd12;
    return bin_to_bcd(b);
  endfunction

  // Returns {pm, hh12}.
  function automatic logic [8:0] hr24_to_12(input bcd2_t h);
    logic [4:0] b;
    logic       p;
    b = bcd_to_bin(h);
    p = (b >= 5'd12);
    if (p)
      b = b - 5'd12;
    if (b == 5'd0)
      b = 5'd12;
    return {p, bin_to_bcd(b)};
  endfunction

endpackage

// File: rtl/clock_bcd_hms_if.sv
// Control/time bus of the BCD clock; alarm signals exist only with CLOCK_BCD_HMS_ALARM_EN.
interface clock_bcd_hms_if;
  import clock_bcd_pkg::*;

  logic  ena;
  logic  mode_24h;
  logic  load;
  bcd2_t load_hh;
  bcd2_t load_mm;
  bcd2_t load_ss;
  logic  load_pm;
  bcd2_t hh;
  bcd2_t mm;
  bcd2_t ss;
  logic  pm;
  logic  day_wrap;
  logic  load_err;
`ifdef CLOCK_BCD_HMS_ALARM_EN
  logic  alarm_set;
  bcd2_t alarm_hh;
  bcd2_t alarm_mm;
  logic  alarm_pm;
  logic  alarm;
`endif

  modport master (
`ifdef CLOCK_BCD_HMS_ALARM_EN
    output alarm_set, alarm_hh, alarm_mm, alarm_pm,
    input  alarm,
`endif
    output ena, mode_24h, load, load_hh, load_mm, load_ss, load_pm,
    input  hh, mm, ss, pm, day_wrap, load_err
  );

  modport slave (
`ifdef CLOCK_BCD_HMS_ALARM_EN
    input  alarm_set, alarm_hh, alarm_mm, alarm_pm,
    output alarm,
`endif
    input  ena, mode_24h, load, load_hh, load_mm, load_ss, load_pm,
    output hh, mm, ss, pm, day_wrap, load_err
  );

endinterface

// File: rtl/clock_bcd_hms_counter.sv
// Two-digit BCD counter 00..MAX with load priority and a carry-out on wrap.
module bcd_mod_counter
  import clock_bcd_pkg::*;
#(
  parameter bcd2_t MAX = BCD_59
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  inc,
  input  logic  load,
  input  bcd2_t load_val,
  output bcd2_t q,
  output logic  wrap
);

  bcd2_t q_reg;

  assign q    = q_reg;
  assign wrap = inc && (q_reg == MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      q_reg <= '0;
    else if (load)
      q_reg <= load_val;
    else if (inc)
      q_reg <= wrap ? '0 : bcd_inc(q_reg);
  end

endmodule

// File: rtl/clock_bcd_hms.sv
// BCD HH:MM:SS clock with 12h/24h mode, validated load and tick prescaler.
// Optional alarm compare is enabled by defining CLOCK_BCD_HMS_ALARM_EN.
module clock_bcd_hms
  import clock_bcd_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int TICK_W   = 16
) (
  input logic            clk,
  input logic            reset_n,
  clock_bcd_hms_if.slave bus
);

  logic [TICK_W-1:0] presc_reg;
  logic  mode_q_reg, pend_reg, pm_reg, day_wrap_reg, load_err_reg;
  bcd2_t hh_reg;
  bcd2_t ss_q, mm_q;
  logic  load_ok, load_v, mode_chg, fire, do_tick, ss_wrap, mm_wrap, alarm_bad;
  bcd2_t hh_tick;
  logic  pm_tick, dw_tick;

  assign load_ok = bcd_valid(bus.load_mm, BCD_59) && bcd_valid(bus.load_ss, BCD_59) &&
                   (bus.mode_24h ? bcd_valid(bus.load_hh, BCD_23)
                                 : (bcd_valid(bus.load_hh, BCD_12) && bus.load_hh != 8'h00));
  assign load_v   = bus.load && load_ok;
  assign fire     = !bus.load && bus.ena && (presc_reg == TICK_W'(TICK_DIV - 1));
  assign mode_chg = !bus.load && (bus.mode_24h != mode_q_reg);
  // A tick swallowed by a mode change waits in pend_reg for the next free cycle.
  assign do_tick  = !bus.load && !mode_chg && (fire || pend_reg);

  bcd_mod_counter #(.MAX(BCD_59)) u_ss (
    .clk(clk), .reset_n(reset_n), .inc(do_tick), .load(load_v),
    .load_val(bus.load_ss), .q(ss_q), .wrap(ss_wrap)
  );

  bcd_mod_counter #(.MAX(BCD_59)) u_mm (
    .clk(clk), .reset_n(reset_n), .inc(ss_wrap), .load(load_v),
    .load_val(bus.load_mm), .q(mm_q), .wrap(mm_wrap)
  );

  always_comb begin
    hh_tick = bcd_inc(hh_reg);
    pm_tick = pm_reg;
    dw_tick = 1'b0;
    if (mode_q_reg) begin
      if (hh_reg == BCD_23) begin
        hh_tick = 8'h00;
        dw_tick = 1'b1;
      end
    end else if (hh_reg == 8'h11) begin
      hh_tick = BCD_12;
      pm_tick = !pm_reg;
      dw_tick = pm_reg;
    end else if (hh_reg == BCD_12) begin
      hh_tick = 8'h01;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg    <= '0;
      mode_q_reg   <= bus.mode_24h;
      pend_reg     <= 1'b0;
      hh_reg       <= bus.mode_24h ? 8'h00 : BCD_12;
      pm_reg       <= 1'b0;
      day_wrap_reg <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      day_wrap_reg <= 1'b0;
      load_err_reg <= (bus.load && !load_ok) || alarm_bad;
      if (bus.load) begin
        if (load_ok) begin
          presc_reg  <= '0;
          pend_reg   <= 1'b0;
          mode_q_reg <= bus.mode_24h;
          hh_reg     <= bus.load_hh;
          pm_reg     <= !bus.mode_24h && bus.load_pm;
        end
      end else begin
        if (bus.ena)
          presc_reg <= fire ? '0 : presc_reg + 1'b1;
        if (mode_chg) begin
          mode_q_reg <= bus.mode_24h;
          pend_reg   <= pend_reg || fire;
          if (bus.mode_24h) begin
            hh_reg <= hr12_to_24(hh_reg, pm_reg);
            pm_reg <= 1'b0;
          end else begin
            {pm_reg, hh_reg} <= hr24_to_12(hh_reg);
          end
        end else if (do_tick) begin
          pend_reg <= pend_reg && fire;
          if (mm_wrap) begin
            hh_reg       <= hh_tick;
            pm_reg       <= pm_tick;
            day_wrap_reg <= dw_tick;
          end
        end
      end
    end
  end

`ifdef CLOCK_BCD_HMS_ALARM_EN
  logic  alarm_arm_reg, alarm_reg, alarm_ok;
  bcd2_t alarm_hh_reg, alarm_mm_reg, hh24_next, mm_next;

  assign alarm_ok  = bcd_valid(bus.alarm_mm, BCD_59) &&
                     (bus.mode_24h ? bcd_valid(bus.alarm_hh, BCD_23)
                                   : (bcd_valid(bus.alarm_hh, BCD_12) && bus.alarm_hh != 8'h00));
  assign alarm_bad = bus.alarm_set && !alarm_ok;
  assign mm_next   = mm_wrap ? 8'h00 : bcd_inc(mm_q);
  // Compare against the time the tick is about to produce, normalised to 24h.
  assign hh24_next = mm_wrap ? (mode_q_reg ? hh_tick : hr12_to_24(hh_tick, pm_tick))
                             : (mode_q_reg ? hh_reg  : hr12_to_24(hh_reg, pm_reg));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_arm_reg <= 1'b0;
      alarm_reg     <= 1'b0;
      alarm_hh_reg  <= '0;
      alarm_mm_reg  <= '0;
    end else begin
      alarm_reg <= alarm_arm_reg && ss_wrap && (mm_next == alarm_mm_reg) &&
                   (hh24_next == alarm_hh_reg);
      if (bus.alarm_set && alarm_ok) begin
        alarm_arm_reg <= 1'b1;
        alarm_mm_reg  <= bus.alarm_mm;
        alarm_hh_reg  <= bus.mode_24h ? bus.alarm_hh : hr12_to_24(bus.alarm_hh, bus.alarm_pm);
      end
    end
  end

  assign bus.alarm = alarm_reg;
`else
  assign alarm_bad = 1'b0;
`endif

  assign bus.hh       = hh_reg;
  assign bus.mm       = mm_q;
  assign bus.ss       = ss_q;
  assign bus.pm       = pm_reg;
  assign bus.day_wrap = day_wrap_reg;
  assign bus.load_err = load_err_reg;

endmodule

// File: tb/tb_clock_bcd_hms.sv
// Randomised bench for clock_bcd_hms: two instances (TICK_DIV 1 and 4) against a seconds-of-day model.
module tb_clock_bcd_hms;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ena, mode_24h, load, load_pm;
  logic [7:0] load_hh, load_mm, load_ss;

  logic [7:0] o_hh [2];
  logic [7:0] o_mm [2];
  logic [7:0] o_ss [2];
  logic       o_pm [2];
  logic       o_dw [2];
  logic       o_le [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    clock_bcd_hms_if bus_if ();
    assign bus_if.ena      = ena;
    assign bus_if.mode_24h = mode_24h;
    assign bus_if.load     = load;
    assign bus_if.load_hh  = load_hh;
    assign bus_if.load_mm  = load_mm;
    assign bus_if.load_ss  = load_ss;
    assign bus_if.load_pm  = load_pm;
`ifdef CLOCK_BCD_HMS_ALARM_EN
    assign bus_if.alarm_set = 1'b0;
    assign bus_if.alarm_hh  = 8'h00;
    assign bus_if.alarm_mm  = 8'h00;
    assign bus_if.alarm_pm  = 1'b0;
`endif
    assign o_hh[gi] = bus_if.hh;
    assign o_mm[gi] = bus_if.mm;
    assign o_ss[gi] = bus_if.ss;
    assign o_pm[gi] = bus_if.pm;
    assign o_dw[gi] = bus_if.day_wrap;
    assign o_le[gi] = bus_if.load_err;

    clock_bcd_hms #(.TICK_DIV(gi == 0 ? 1 : 4), .TICK_W(16)) u_dut (
      .clk(clk), .reset_n(reset_n), .bus(bus_if)
    );
  end

  // Reference model: time is plain seconds since midnight; display is derived from it.
  int t_m [2];
  int cnt_m [2];
  bit pend_m [2];
  bit mq_m [2];
  bit dw_m [2];
  bit le_m [2];

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic bit decode_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                     input bit p, input bit m24, output int secs);
    int hv, mv, sv;
    bit ok;
    ok = h[7:4] <= 9 && h[3:0] <= 9 && m[7:4] <= 9 && m[3:0] <= 9 && s[7:4] <= 9 && s[3:0] <= 9;
    hv = h[7:4] * 10 + h[3:0];
    mv = m[7:4] * 10 + m[3:0];
    sv = s[7:4] * 10 + s[3:0];
    ok = ok && mv < 60 && sv < 60 && (m24 ? hv < 24 : (hv >= 1 && hv <= 12));
    if (!m24)
      hv = (hv % 12) + (p ? 12 : 0);
    secs = hv * 3600 + mv * 60 + sv;
    return ok;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int  div, secs;
      bit  fire;
      div = (d == 0) ? 1 : 4;
      if (!reset_n) begin
        t_m[d] = 0; cnt_m[d] = 0; pend_m[d] = 0; mq_m[d] = mode_24h; dw_m[d] = 0; le_m[d] = 0;
      end else begin
        dw_m[d] = 0;
        le_m[d] = 0;
        if (load) begin
          if (decode_load(load_hh, load_mm, load_ss, load_pm, mode_24h, secs)) begin
            t_m[d] = secs; cnt_m[d] = 0; pend_m[d] = 0; mq_m[d] = mode_24h;
          end else begin
            le_m[d] = 1;
          end
        end else begin
          fire = ena && (cnt_m[d] == div - 1);
          if (ena)
            cnt_m[d] = fire ? 0 : cnt_m[d] + 1;
          if (mode_24h != mq_m[d]) begin
            mq_m[d] = mode_24h;
            pend_m[d] = pend_m[d] || fire;
          end else if (fire || pend_m[d]) begin
            t_m[d] = (t_m[d] + 1) % 86400;
            dw_m[d] = (t_m[d] == 0);
            pend_m[d] = pend_m[d] && fire;
          end
        end
      end
    end
  end

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s dut%0d: got %0h want %0h", name, d, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      for (int d = 0; d < 2; d++) begin
        int hr;
        hr = t_m[d] / 3600;
        check("hh", d, 32'(o_hh[d]),
              32'(mq_m[d] ? to_bcd(hr) : to_bcd((hr % 12 == 0) ? 12 : hr % 12)));
        check("mm", d, 32'(o_mm[d]), 32'(to_bcd((t_m[d] / 60) % 60)));
        check("ss", d, 32'(o_ss[d]), 32'(to_bcd(t_m[d] % 60)));
        check("pm", d, 32'(o_pm[d]), 32'(!mq_m[d] && hr >= 12));
        check("day_wrap", d, 32'(o_dw[d]), 32'(dw_m[d]));
        check("load_err", d, 32'(o_le[d]), 32'(le_m[d]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ld(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
    load_hh = h; load_mm = m; load_ss = s; load_pm = p; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      ena = 1'b1; step(1);
      ena = 1'b0; step(1);
    end
  endtask

  function automatic logic [7:0] rnd_bcd(input int hi);
    int v;
    v = $urandom_range(0, hi);
    return to_bcd(v);
  endfunction

  initial begin
    reset_n = 1'b0; ena = 1'b0; mode_24h = 1'b0; load = 1'b0;
    load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00; load_pm = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(1);
    check("rst_hh", 0, 32'(o_hh[0]), 32'h12);
    check("rst_pm", 0, 32'(o_pm[0]), 32'h0);

    ena = 1'b1; step(3600); ena = 1'b0;
    check("hour_hh", 0, 32'(o_hh[0]), 32'h01);
    check("hour_mm", 0, 32'(o_mm[0]), 32'h00);
    check("hour_ss", 0, 32'(o_ss[0]), 32'h00);
    check("div4_mm", 1, 32'(o_mm[1]), 32'h15);

    ld(8'h11, 8'h59, 8'h59, 1'b1);
    check("ld_pm", 0, 32'(o_pm[0]), 32'h1);
    ena = 1'b1; step(1); ena = 1'b0;
    check("mid_hh", 0, 32'(o_hh[0]), 32'h12);
    check("mid_pm", 0, 32'(o_pm[0]), 32'h0);
    check("mid_dw", 0, 32'(o_dw[0]), 32'h1);
    step(1);
    check("mid_dw_off", 0, 32'(o_dw[0]), 32'h0);

    ld(8'h12, 8'h30, 8'h00, 1'b1);
    mode_24h = 1'b1; step(1);
    check("to24_hh", 0, 32'(o_hh[0]), 32'h12);
    check("to24_pm", 0, 32'(o_pm[0]), 32'h0);
    ld(8'h00, 8'h00, 8'h00, 1'b0);
    mode_24h = 1'b0; step(1);
    check("to12_hh", 0, 32'(o_hh[0]), 32'h12);
    check("to12_pm", 0, 32'(o_pm[0]), 32'h0);

    ld(8'h13, 8'h00, 8'h00, 1'b0);
    check("err_hh13", 0, 32'(o_le[0]), 32'h1);
    check("err_keep", 0, 32'(o_hh[0]), 32'h12);
    ld(8'h05, 8'h5A, 8'h00, 1'b0);
    check("err_mm5a", 0, 32'(o_le[0]), 32'h1);
    ena = 1'b1;
    ld(8'h05, 8'h10, 8'h20, 1'b0);
    ena = 1'b0;
    check("ld_ena_ss", 0, 32'(o_ss[0]), 32'h20);
    check("ld_ena_hh", 0, 32'(o_hh[0]), 32'h05);

    reset_n = 1'b0; step(2); reset_n = 1'b1; step(1);
    pulses(8);
    check("div4_ss", 1, 32'(o_ss[1]), 32'h02);
    pulses(3);
    reset_n = 1'b0; step(1); reset_n = 1'b1; step(1);
    pulses(3);
    check("div4_rst", 1, 32'(o_ss[1]), 32'h00);

    for (int i = 0; i < 4000; i++) begin
      ena  = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 31) == 0);
      if (load) begin
        load_hh = ($urandom_range(0, 7) == 0) ? 8'($urandom) : rnd_bcd(23);
        load_mm = ($urandom_range(0, 1) == 0) ? 8'h59 : rnd_bcd(59);
        load_ss = ($urandom_range(0, 1) == 0) ? 8'h59 : rnd_bcd(59);
        load_pm = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 49) == 0)
        mode_24h = !mode_24h;
      reset_n = ($urandom_range(0, 999) != 0);
      step(1);
    end
    load = 1'b0; ena = 1'b0; reset_n = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
